// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: sequential restoring divider controller for the CPU DIV operation.
// Latches a dividend/divisor pair on start, runs one restoring step per clock for
// WIDTH cycles, then applies signs and pulses done with quotient (LO) and
// remainder (HI). A zero divisor short-circuits straight to DONE.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic             sign_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_ITER  = 3'd2,
        S_FIX   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic               r_sign;     // sign_op captured at start
    logic [WIDTH-1:0]   r_dvd;      // raw dividend captured at start
    logic [WIDTH-1:0]   r_dvs;      // raw divisor captured at start
    logic [WIDTH-1:0]   r_d;        // dividend magnitude, shifts out MSB-first, collects quotient bits
    logic [WIDTH-1:0]   r_m;        // divisor magnitude
    logic [WIDTH-1:0]   r_p;        // partial remainder; always < r_m so WIDTH bits suffice between steps
    logic [CNT_W-1:0]   r_cnt;
    logic               r_q_neg;
    logic               r_r_neg;

    logic [WIDTH-1:0]   w_dvd_abs;
    logic [WIDTH-1:0]   w_dvs_abs;
    logic [WIDTH:0]     w_p_sh;     // (WIDTH+1)-bit shifted partial remainder
    logic [WIDTH:0]     w_t;        // trial subtraction; MSB set means borrow
    logic               w_last;

    // Magnitudes for the signed path; unsigned ops pass raw values through.
    // -0x8000... wraps to itself, which is the correct unsigned magnitude.
    assign w_dvd_abs = (r_sign && r_dvd[WIDTH-1]) ? -r_dvd : r_dvd;
    assign w_dvs_abs = (r_sign && r_dvs[WIDTH-1]) ? -r_dvs : r_dvs;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    assign w_p_sh = {r_p, r_d[WIDTH-1]};
    assign w_t    = w_p_sh - {1'b0, r_m};
    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and status outputs.
    // NOTE: defaults come first so no path leaves an output unassigned (no latch inferred).
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SETUP;
            S_SETUP: begin
                busy   = 1'b1;
                w_next = (r_dvs == '0) ? S_DONE : S_ITER;
            end
            S_ITER: begin
                busy = 1'b1;
                if (w_last) w_next = S_FIX;
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, magnitude setup, iteration and result write-back.
    // NOTE: every datapath and result register is reset so an aborted operation leaves no stale state.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sign    <= 1'b0;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_d       <= '0;
            r_m       <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign   <= sign_op;
                        r_dvd    <= dividend;
                        r_dvs    <= divisor;
                        div_zero <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (r_dvs == '0) begin
                        div_zero  <= 1'b1;
                        quotient  <= '1;
                        remainder <= r_dvd;
                    end else begin
                        r_d     <= w_dvd_abs;
                        r_m     <= w_dvs_abs;
                        r_q_neg <= r_sign & (r_dvd[WIDTH-1] ^ r_dvs[WIDTH-1]);
                        r_r_neg <= r_sign & r_dvd[WIDTH-1];
                        r_p     <= '0;
                        r_cnt   <= '0;
                    end
                end
                S_ITER: begin
                    if (w_t[WIDTH]) begin
                        r_p <= w_p_sh[WIDTH-1:0];
                        r_d <= {r_d[WIDTH-2:0], 1'b0};
                    end else begin
                        r_p <= w_t[WIDTH-1:0];
                        r_d <= {r_d[WIDTH-2:0], 1'b1};
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    quotient  <= r_q_neg ? -r_d : r_d;
                    remainder <= r_r_neg ? -r_p : r_p;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: directed self-checking bench for div_seq_ctrl (WIDTH=32).
// Expected quotients, remainders and edge counts are hand-computed constants.
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         clr_n;
    logic         start;
    logic         sign_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    int n_checks = 0;
    int n_errors = 0;

    div_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .start     (start),
        .sign_op   (sign_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Launch one operation and follow it to its done pulse. exp_lat is the number of
    // edges after the accepting edge E0 at which done is first seen high.
    // With inject set, extra start pulses with different operands hit edges E0+5 and E0+20.
    task automatic run_op(input string tag, input logic sgn,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                          input logic exp_dz, input int exp_lat, input logic inject);
        int  n;
        bit  seen;
        @(negedge clk);
        sign_op  = sgn;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'h0000_0003;
        divisor  = 32'h0000_0000;
        sign_op  = ~sgn;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        check({tag, "_dz_cleared"}, 32'(div_zero), 32'd0);
        seen = 1'b0;
        n    = 0;
        while (n < 200 && !seen) begin
            n++;
            if (inject) start = (n == 5 || n == 20);
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({tag, "_latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_lat));
        check({tag, "_quotient"}, quotient, exp_q);
        check({tag, "_remainder"}, remainder, exp_r);
        check({tag, "_div_zero"}, 32'(div_zero), 32'(exp_dz));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_quotient_held"}, quotient, exp_q);
        if (inject) begin
            // No second operation may have been queued by the ignored pulses.
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_no_requeue"}, 32'(busy | done), 32'd0);
        end
    endtask

    initial begin
        clr_n    = 1'b0;
        start    = 1'b0;
        sign_op  = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_dz", 32'(div_zero), 32'd0);
        check("reset_q", quotient, 32'd0);
        check("reset_r", remainder, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;

        // Unsigned and signed basics.
        run_op("u100_7",  1'b0, 32'd100,      32'd7,        32'h0000_000E, 32'h0000_0002, 1'b0, 34, 1'b0);
        run_op("s-100_7", 1'b1, 32'hFFFF_FF9C, 32'd7,       32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34, 1'b0);
        run_op("s100_-7", 1'b1, 32'd100,      32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0, 34, 1'b0);
        run_op("s-7_-2",  1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0, 34, 1'b0);

        // Divide by zero under both signedness modes, then a normal op clears div_zero.
        run_op("u7_0",    1'b0, 32'd7,        32'd0,        32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 1,  1'b0);
        run_op("s7_0",    1'b1, 32'd7,        32'd0,        32'hFFFF_FFFF, 32'h0000_0007, 1'b1, 1,  1'b0);
        run_op("u9_4",    1'b0, 32'd9,        32'd4,        32'h0000_0002, 32'h0000_0001, 1'b0, 34, 1'b0);

        // Boundary operands.
        run_op("s_min_-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0, 34, 1'b0);
        run_op("u_max_1",  1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 34, 1'b0);
        run_op("u_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, 34, 1'b0);

        // Start pulses during an operation are ignored.
        run_op("inject",  1'b0, 32'd1000,     32'd3,        32'h0000_014D, 32'h0000_0001, 1'b0, 34, 1'b1);

        // Asynchronous reset in the middle of the iterations.
        @(negedge clk);
        sign_op  = 1'b0;
        dividend = 32'd1000;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_dz", 32'(div_zero), 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) check("abort_spurious_done", 32'(done), 32'd0);
        end
        run_op("after_abort", 1'b0, 32'd1000, 32'd7, 32'h0000_008E, 32'h0000_0006, 1'b0, 34, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
